// File: rtl/dm_arb_pkg.sv
// Shared types and limits for the data-memory port arbiter.
// ADDRESS_SIZE / DATA_SIZE are normally provided by defines.vh; fallbacks keep standalone builds complete.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package dm_arb_pkg;

  localparam int DM_ARB_WAIT_MIN = 1;
  localparam int DM_ARB_WAIT_MAX = 15;
  localparam int DM_ARB_AW       = `ADDRESS_SIZE;
  localparam int DM_ARB_DW       = `DATA_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dm_arb_state_t;

  typedef enum logic {
    OWN_MEM = 1'b0,
    OWN_DBG = 1'b1
  } dm_arb_owner_t;

  // Transaction latched at grant time and held until DONE.
  typedef struct packed {
    dm_arb_owner_t          owner;
    logic                   we;
    logic [DM_ARB_AW-1:0]   addr;
    logic [DM_ARB_DW-1:0]   wdata;
  } dm_arb_xact_t;

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way request picker: round-robin when DM_ARB_RR_EN is defined, else fixed MEM-over-DBG priority.
// Purely combinational; a lone request always wins.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic          req_mem,
  input  logic          req_dbg,
  input  dm_arb_owner_t last_grant,
  output logic          valid,
  output dm_arb_owner_t winner
);

  assign valid = req_mem | req_dbg;

`ifdef DM_ARB_RR_EN
  always_comb begin
    winner = OWN_MEM;
    if (req_mem && req_dbg) begin
      winner = (last_grant == OWN_MEM) ? OWN_DBG : OWN_MEM;
    end else if (req_dbg) begin
      winner = OWN_DBG;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = OWN_MEM;
    if (!req_mem && req_dbg) begin
      winner = OWN_DBG;
    end
  end
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Sequences the single data-memory port between the MEM stage and a debug/loader requester.
// Fixed WAIT_CYCLES busy window per access; optional round-robin arbitration via DM_ARB_RR_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DM_ARB_AW-1:0]  mem_addr,
  input  logic [DM_ARB_DW-1:0]  mem_wdata,
  output logic [DM_ARB_DW-1:0]  mem_rdata,
  output logic                  mem_done,
  output logic                  mem_stall_c,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ARB_AW-1:0]  dbg_addr,
  input  logic [DM_ARB_DW-1:0]  dbg_wdata,
  output logic [DM_ARB_DW-1:0]  dbg_rdata,
  output logic                  dbg_done,

  input  logic [DM_ARB_DW-1:0]  dm_read_data,
  output logic                  dm_write_enable,
  output logic [DM_ARB_AW-1:0]  dm_write_address,
  output logic [DM_ARB_DW-1:0]  dm_write_data,
  output logic [DM_ARB_AW-1:0]  dm_read_address
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             SINGLE_WAIT = (WAIT_CYCLES == 1);

  dm_arb_state_t  state;
  logic [CNT_W-1:0] cnt;
  dm_arb_xact_t   xact;
  dm_arb_owner_t  last_grant;

  logic           pick_vld;
  dm_arb_owner_t  pick_win;
  logic           sel_we;
  logic [DM_ARB_AW-1:0] sel_addr;
  logic [DM_ARB_DW-1:0] sel_wdata;

  dm_arb_pick u_pick (
    .req_mem    (mem_req),
    .req_dbg    (dbg_req),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .winner     (pick_win)
  );

  always_comb begin
    sel_we    = mem_we;
    sel_addr  = mem_addr;
    sel_wdata = mem_wdata;
    if (pick_win == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

`ifdef DM_ARB_RR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWN_DBG;
    end else if (state == ST_IDLE && pick_vld) begin
      last_grant <= pick_win;
    end
  end
`else
  assign last_grant = OWN_DBG;
`endif

  // Stall drops only in the cycle the MEM access completes.
  assign mem_stall_c = mem_req & ~((state == ST_DONE) && (xact.owner == OWN_MEM));

  // The dm_* port is driven from registers set up one edge ahead, so the
  // single write strobe lands in the last BUSY cycle without a comb path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      xact             <= '0;
      mem_rdata        <= '0;
      dbg_rdata        <= '0;
      mem_done         <= 1'b0;
      dbg_done         <= 1'b0;
      dm_write_enable  <= 1'b0;
      dm_write_address <= '0;
      dm_write_data    <= '0;
      dm_read_address  <= '0;
    end else begin
      mem_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state            <= ST_BUSY;
            cnt              <= CNT_LOAD;
            xact             <= '{owner: pick_win, we: sel_we, addr: sel_addr, wdata: sel_wdata};
            dm_read_address  <= sel_we ? '0 : sel_addr;
            dm_write_address <= sel_we ? sel_addr : '0;
            dm_write_data    <= sel_we ? sel_wdata : '0;
            dm_write_enable  <= sel_we & SINGLE_WAIT;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state            <= ST_DONE;
            dm_write_enable  <= 1'b0;
            dm_write_address <= '0;
            dm_write_data    <= '0;
            dm_read_address  <= '0;
            if (xact.owner == OWN_MEM) begin
              mem_done <= 1'b1;
              if (!xact.we) mem_rdata <= dm_read_data;
            end else begin
              dbg_done <= 1'b1;
              if (!xact.we) dbg_rdata <= dm_read_data;
            end
          end else begin
            cnt             <= cnt - CNT_ONE;
            dm_write_enable <= xact.we & (cnt == CNT_ONE);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
